cpr_cue_arbiter: RTL and testbench

CPR_CUE_ARBITER -- requirements
Module: cpr_cue_arbiter

---
 rtl/cpr_cue_arbiter.sv | 146 ++++++++++++++
 tb/tb_cpr_cue_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cpr_cue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpr_cue_arbiter
// Description : Three-way priority arbiter for CPR audio cues sharing one
//               piezo. The winner plays its square-wave tone for at least
//               MIN_HOLD cycles, followed by a GAP_CYCLES silent gap.
// Revision    : 1.0 - initial release
// ============================================================================
module cpr_cue_arbiter #(
  parameter int unsigned TONE_DIV_B = 25_000,
  parameter int unsigned TONE_DIV_C = 12_500,
  parameter int unsigned TONE_DIV_P = 50_000,
  parameter int unsigned MIN_HOLD   = 1_000_000,
  parameter int unsigned GAP_CYCLES = 250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       req_breath,
  input  logic       req_compress,
  input  logic       req_pulse,
  output logic       cue_out,
  output logic [2:0] grant,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Terminal counts; degenerate zero settings collapse to a one-cycle period.
  localparam logic [31:0] C_LAST_B    = (TONE_DIV_B > 1) ? TONE_DIV_B - 32'd1 : 32'd0;
  localparam logic [31:0] C_LAST_C    = (TONE_DIV_C > 1) ? TONE_DIV_C - 32'd1 : 32'd0;
  localparam logic [31:0] C_LAST_P    = (TONE_DIV_P > 1) ? TONE_DIV_P - 32'd1 : 32'd0;
  localparam logic [31:0] C_HOLD_LAST = (MIN_HOLD > 1) ? MIN_HOLD - 32'd1 : 32'd0;
  localparam logic [31:0] C_GAP_LAST  = (GAP_CYCLES > 1) ? GAP_CYCLES - 32'd1 : 32'd0;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_tone_cnt;
  logic [31:0] r_hold_cnt;
  logic [31:0] r_gap_cnt;
  logic [31:0] w_tone_nxt;
  logic [31:0] w_hold_nxt;
  logic [31:0] w_gap_nxt;
  logic [2:0]  w_grant_nxt;
  logic        w_cue_nxt;
  logic        w_busy_nxt;

  logic [2:0]  w_req;
  logic [2:0]  w_winner;
  logic [31:0] w_tone_last;
  logic        w_granted_req;
  logic        w_higher_req;
  logic        w_play_done;
  logic        w_gap_done;

  assign w_req         = {req_pulse, req_compress, req_breath};
  assign w_granted_req = |(grant & w_req);
  assign w_play_done   = (r_hold_cnt == C_HOLD_LAST) && (!w_granted_req || w_higher_req);
  assign w_gap_done    = (r_gap_cnt == C_GAP_LAST);

  // Fixed-priority winner and per-owner tone/preemption lookups.
  always_comb begin
    w_winner     = 3'b000;
    w_tone_last  = C_LAST_B;
    w_higher_req = 1'b0;
    if (req_pulse)         w_winner = 3'b100;
    else if (req_compress) w_winner = 3'b010;
    else if (req_breath)   w_winner = 3'b001;
    case (grant)
      3'b100:  w_tone_last = C_LAST_P;
      3'b010:  begin w_tone_last = C_LAST_C; w_higher_req = req_pulse; end
      3'b001:  begin w_tone_last = C_LAST_B; w_higher_req = req_pulse | req_compress; end
      default: w_tone_last = C_LAST_B;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; enable low overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (|w_req) w_state_nxt = S_PLAY;
        S_PLAY:  if (w_play_done) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        S_GAP:   if (w_gap_done) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and counters; any leaving of a
  // state clears everything by default.
  always_comb begin
    w_grant_nxt = 3'b000;
    w_cue_nxt   = 1'b0;
    w_tone_nxt  = 32'd0;
    w_hold_nxt  = 32'd0;
    w_gap_nxt   = 32'd0;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    if (r_state == S_IDLE && w_state_nxt == S_PLAY) begin
      w_grant_nxt = w_winner;
    end else if (r_state == S_PLAY && w_state_nxt == S_PLAY) begin
      w_grant_nxt = grant;
      if (r_tone_cnt >= w_tone_last) begin
        w_tone_nxt = 32'd0;
        w_cue_nxt  = ~cue_out;
      end else begin
        w_tone_nxt = r_tone_cnt + 32'd1;
        w_cue_nxt  = cue_out;
      end
      w_hold_nxt = (r_hold_cnt == C_HOLD_LAST) ? r_hold_cnt : r_hold_cnt + 32'd1;
    end else if (r_state == S_GAP && w_state_nxt == S_GAP) begin
      w_gap_nxt = r_gap_cnt + 32'd1;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= 3'b000;
      cue_out    <= 1'b0;
      busy       <= 1'b0;
      r_tone_cnt <= 32'd0;
      r_hold_cnt <= 32'd0;
      r_gap_cnt  <= 32'd0;
    end else begin
      grant      <= w_grant_nxt;
      cue_out    <= w_cue_nxt;
      busy       <= w_busy_nxt;
      r_tone_cnt <= w_tone_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpr_cue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpr_cue_arbiter
// Description : Vector-table bench for cpr_cue_arbiter with small divisors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpr_cue_arbiter;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       req_breath;
  logic       req_compress;
  logic       req_pulse;
  logic       cue_out;
  logic [2:0] grant;
  logic       busy;

  cpr_cue_arbiter #(
    .TONE_DIV_B (4),
    .TONE_DIV_C (2),
    .TONE_DIV_P (3),
    .MIN_HOLD   (10),
    .GAP_CYCLES (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req_breath   (req_breath),
    .req_compress (req_compress),
    .req_pulse    (req_pulse),
    .cue_out      (cue_out),
    .grant        (grant),
    .busy         (busy)
  );

  typedef struct {
    logic       en;
    logic [2:0] req;    // {pulse, compress, breath}
    logic [2:0] grant;
    logic       cue;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [2:0] grant;
    logic       cue;
    logic       busy;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic e, input logic [2:0] r,
                              input logic [2:0] g, input logic c, input logic b);
    vec_t v;
    v.en = e; v.req = r; v.grant = g; v.cue = c; v.busy = b;
    return v;
  endfunction

  task automatic compare(input exp_t x);
    n_vec++;
    if (grant !== x.grant || cue_out !== x.cue || busy !== x.busy) begin
      n_bad++;
      $display("FAIL %s: got grant=%b cue=%b busy=%b, want grant=%b cue=%b busy=%b",
               x.name, grant, cue_out, busy, x.grant, x.cue, x.busy);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, check them.
  task automatic step(input logic e, input logic [2:0] r, input logic [2:0] g,
                      input logic c, input logic b, input string nm);
    exp_t x;
    @(negedge clk);
    enable = e;
    {req_pulse, req_compress, req_breath} = r;
    x.grant = g; x.cue = c; x.busy = b; x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got grant=%b want a queued entry", nm, grant);
    end else begin
      compare(exp_q.pop_front());
    end
  endtask

  initial begin
    exp_t xr;
    rst = 1'b1; enable = 1'b0;
    req_breath = 1'b0; req_compress = 1'b0; req_pulse = 1'b0;

    // Compress alone, breath ignored while compress plays, then compress drops.
    vecs.push_back(mk(1, 3'b010, 3'b010, 0, 1));
    vecs.push_back(mk(1, 3'b010, 3'b010, 0, 1));
    vecs.push_back(mk(1, 3'b010, 3'b010, 1, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 1, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 0, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 0, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 1, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 1, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 0, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 0, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 1, 1));
    vecs.push_back(mk(1, 3'b011, 3'b010, 1, 1));
    vecs.push_back(mk(1, 3'b001, 3'b000, 0, 1));  // gap 1
    vecs.push_back(mk(1, 3'b001, 3'b000, 0, 1));  // gap 2
    vecs.push_back(mk(1, 3'b001, 3'b000, 0, 1));  // gap 3
    vecs.push_back(mk(1, 3'b001, 3'b000, 0, 0));  // idle
    // Breath re-granted; pulse rises on its third cycle but cannot preempt.
    vecs.push_back(mk(1, 3'b001, 3'b001, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b001, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b001, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b001, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b001, 1, 1));
    vecs.push_back(mk(1, 3'b101, 3'b001, 1, 1));
    vecs.push_back(mk(1, 3'b101, 3'b001, 1, 1));
    vecs.push_back(mk(1, 3'b101, 3'b001, 1, 1));
    vecs.push_back(mk(1, 3'b101, 3'b001, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b001, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b000, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b000, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b000, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b000, 0, 0));
    // Pulse and breath together: pulse wins; pulse drops early, still full hold.
    vecs.push_back(mk(1, 3'b101, 3'b100, 0, 1));
    vecs.push_back(mk(1, 3'b101, 3'b100, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b100, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b100, 1, 1));
    vecs.push_back(mk(1, 3'b001, 3'b100, 1, 1));
    vecs.push_back(mk(1, 3'b001, 3'b100, 1, 1));
    vecs.push_back(mk(1, 3'b001, 3'b100, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b100, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b100, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b100, 1, 1));
    vecs.push_back(mk(1, 3'b001, 3'b000, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b000, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b000, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'b001, 3'b001, 0, 1));
    vecs.push_back(mk(1, 3'b001, 3'b001, 0, 1));
    // Enable drop mid-play, enable low blocks all requests.
    vecs.push_back(mk(0, 3'b001, 3'b000, 0, 0));
    vecs.push_back(mk(0, 3'b111, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'b000, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'b100, 3'b100, 0, 1));
    vecs.push_back(mk(1, 3'b100, 3'b100, 0, 1));
    vecs.push_back(mk(0, 3'b100, 3'b000, 0, 0));
    vecs.push_back(mk(1, 3'b000, 3'b000, 0, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    xr.grant = 3'b000; xr.cue = 1'b0; xr.busy = 1'b0; xr.name = "reset_state";
    compare(xr);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].req, vecs[i].grant, vecs[i].cue, vecs[i].busy,
           $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a gap, request held throughout.
    for (int n = 1; n <= 11; n++) begin
      step(1, 3'b010, 3'b010, 1'(((n - 1) >> 1) & 1), 1, $sformatf("pre_rst_play%0d", n));
    end
    step(1, 3'b000, 3'b000, 0, 1, "pre_rst_gap1");
    step(1, 3'b010, 3'b000, 0, 1, "pre_rst_gap2");
    rst = 1'b1;
    #1;
    xr.grant = 3'b000; xr.cue = 1'b0; xr.busy = 1'b0; xr.name = "rst_async_mid_gap";
    compare(xr);
    #1;
    rst = 1'b0;
    step(1, 3'b010, 3'b010, 0, 1, "post_rst_grant");
    step(1, 3'b010, 3'b010, 0, 1, "post_rst_play2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
